sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Sequences the single external SRAM bank shared by the instruction-fetch port and the data (load/store) port. Both ports present physical word addresses already translated upstream.
- Performs round-robin arbitration with data-first tie-break, generates SRAM control-strobe timing for reads and writes, returns read data, and raises a pipeline stall while any request is outstanding.
- Sits between the address-translation stage and the SRAM pins.

Parameters:
- READ_WAIT, 1, extra wait cycles after the first read-access cycle before data is captured (0..7).
- WE_PULSE, 1, cycles sram_we_n_o is held low during a write (1..7).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- inst_req_i  in  1  fetch request; held high until inst_ack_o
- inst_addr_i  in  20  fetch word address
- inst_rdata_o  out  32  fetched word; valid when inst_ack_o=1
- inst_ack_o  out  1  one-cycle completion pulse
- data_req_i  in  1  data request; held high until data_ack_o
- data_we_i  in  1  1=store, 0=load
- data_be_i  in  4  byte enables, active high
- data_addr_i  in  20  data word address
- data_wdata_i  in  32  store data
- data_rdata_o  out  32  load word; valid when data_ack_o=1
- data_ack_o  out  1  one-cycle completion pulse
- stall_o  out  1  pipeline stall
- sram_addr_o  out  20  SRAM address
- sram_wdata_o  out  32  SRAM write data
- sram_rdata_i  in  32  SRAM read data
- sram_dq_oe_o  out  1  drive enable for the bidirectional data bus
- sram_ce_n_o  out  1  chip enable, active low
- sram_oe_n_o  out  1  output enable, active low
- sram_we_n_o  out  1  write enable, active low
- sram_be_n_o  out  4  byte enables, active low

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: state=IDLE; acks=0; rdata outputs=0; sram_ce_n/oe_n/we_n=1; sram_be_n=4'hF; sram_dq_oe=0; sram_addr=0; sram_wdata=0; last_grant=INST.
- Reset mid-operation: abort at the next edge, return to IDLE, issue no ack, and leave strobes inactive.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE arbitration:
  - A port whose ack_o is high this cycle is ignored.
  - If only one port requests, grant it.
  - If both request, grant DATA unless last_grant=DATA, in which case grant INST.
- At grant:
  - Latch address, we, be and wdata.
  - Update last_grant.
  - INST grants are always reads with be=4'hF.
- Read path (RD): ce_n=0, oe_n=0, be_n=~be, dq_oe=0, held for READ_WAIT+1 cycles. sram_rdata_i is captured on the last RD cycle, then the FSM goes to DONE.
- Write path:
  - WR_SETUP: 1 cycle; ce_n=0, we_n=1, dq_oe=1, addr/wdata/be driven.
  - WR_PULSE: WE_PULSE cycles; we_n=0.
  - WR_HOLD: 1 cycle; we_n=1, dq_oe=1, addr and data stable.
  - Then DONE.
- Store with data_be_i=4'h0: grant, skip SRAM (no strobes), go straight to DONE.
- DONE: 1 cycle; granted port's ack_o=1 and its rdata_o=captured word (held until that port's next ack); all strobes inactive; next cycle IDLE.
- Latency, grant cycle to ack cycle:
  - Read: READ_WAIT+2.
  - Write: WE_PULSE+3.
  - Zero-byte store: 1.
- stall_o = (inst_req_i & ~inst_ack_o) | (data_req_i & ~data_ack_o), combinational.
- Request inputs change while a transaction is in flight: ignored, since latched values are used.

Optional Feature:
- Macro SRAM_ARB_IBUF_EN.
- When defined: a one-entry instruction buffer holds {valid, addr, word} of the last completed INST read.
  - An INST request whose address matches a valid entry is granted in IDLE and goes to DONE without SRAM access (ack 1 cycle after grant).
  - Buffer is cleared by reset and by any data store to the same address with non-zero be.
- When undefined: every fetch accesses SRAM.

Test Plan:
- INST read, READ_WAIT=1, addr=20'h00010, SRAM returns 32'h2402_0005 -> ce_n/oe_n low 2 cycles, inst_ack_o pulses 3 cycles after grant with inst_rdata_o=32'h2402_0005, stall_o high until the ack cycle.
- DATA store, WE_PULSE=1, addr=20'h00400, be=4'b0011, wdata=32'hDEAD_BEEF -> we_n low exactly 1 cycle, be_n=4'b1100, dq_oe high for 3 cycles, data_ack_o 4 cycles after grant.
- Both ports request continuously with last_grant=INST -> grant order DATA, INST, DATA, INST; no back-to-back grant to the same port.
- DATA store be=4'h0 -> data_ack_o 1 cycle after grant, sram_ce_n_o never low.
- rst asserted during WR_PULSE -> next edge we_n=1, dq_oe=0, state IDLE, no ack emitted.
- SRAM_ARB_IBUF_EN: fetch 20'h00020 twice -> second acks in 1 cycle with no SRAM strobes; store to 20'h00020 then fetch -> SRAM read occurs.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Round-robin sequencer for the single SRAM bank shared by the fetch and load/store ports.
// Define SRAM_ARB_IBUF_EN to add a one-entry buffer holding the last fetched word.
module sram_port_arbiter #(
    parameter int READ_WAIT = 1,
    parameter int WE_PULSE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req_i,
    input  logic [19:0] inst_addr_i,
    output logic [31:0] inst_rdata_o,
    output logic        inst_ack_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [19:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_ack_o,
    output logic        stall_o,
    output logic [19:0] sram_addr_o,
    output logic [31:0] sram_wdata_o,
    input  logic [31:0] sram_rdata_i,
    output logic        sram_dq_oe_o,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o,
    output logic [3:0]  sram_be_n_o
);

    typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

    localparam logic       GNT_INST = 1'b0;
    localparam logic       GNT_DATA = 1'b1;
    localparam logic [2:0] RD_LAST  = 3'(READ_WAIT);
    localparam logic [2:0] WE_LAST  = 3'(WE_PULSE - 1);

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [19:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;

`ifdef SRAM_ARB_IBUF_EN
    logic        ibuf_valid_q, ibuf_valid_d;
    logic [19:0] ibuf_addr_q, ibuf_addr_d;
    logic [31:0] ibuf_word_q, ibuf_word_d;
    logic        ibuf_hit;

    assign ibuf_hit = ibuf_valid_q && (ibuf_addr_q == inst_addr_i);
`endif

    logic inst_req_eff;
    logic data_req_eff;
    logic grant_data;

    assign inst_ack_o   = (state_q == DONE) && (last_grant_q == GNT_INST);
    assign data_ack_o   = (state_q == DONE) && (last_grant_q == GNT_DATA);
    assign inst_req_eff = inst_req_i & ~inst_ack_o;
    assign data_req_eff = data_req_i & ~data_ack_o;
    // Data wins a tie unless it also won the previous grant.
    assign grant_data   = data_req_eff & (~inst_req_eff | (last_grant_q == GNT_INST));
    assign stall_o      = (inst_req_i & ~inst_ack_o) | (data_req_i & ~data_ack_o);

    assign inst_rdata_o = inst_rdata_q;
    assign data_rdata_o = data_rdata_q;
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
`ifdef SRAM_ARB_IBUF_EN
        ibuf_valid_d = ibuf_valid_q;
        ibuf_addr_d  = ibuf_addr_q;
        ibuf_word_d  = ibuf_word_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = 3'd0;
                if (grant_data) begin
                    last_grant_d = GNT_DATA;
                    addr_d       = data_addr_i;
                    we_d         = data_we_i;
                    be_d         = data_be_i;
                    wdata_d      = data_wdata_i;
                    if (data_we_i && (data_be_i == 4'h0)) state_d = DONE;
                    else if (data_we_i)                   state_d = WR_SETUP;
                    else                                  state_d = RD;
`ifdef SRAM_ARB_IBUF_EN
                    if (data_we_i && (data_be_i != 4'h0) && (data_addr_i == ibuf_addr_q))
                        ibuf_valid_d = 1'b0;
`endif
                end else if (inst_req_eff) begin
                    last_grant_d = GNT_INST;
                    addr_d       = inst_addr_i;
                    we_d         = 1'b0;
                    be_d         = 4'hF;
                    state_d      = RD;
`ifdef SRAM_ARB_IBUF_EN
                    if (ibuf_hit) begin
                        state_d      = DONE;
                        inst_rdata_d = ibuf_word_q;
                    end
`endif
                end
            end
            RD: begin
                if (cnt_q == RD_LAST) begin
                    state_d = DONE;
                    if (last_grant_q == GNT_DATA) begin
                        data_rdata_d = sram_rdata_i;
                    end else begin
                        inst_rdata_d = sram_rdata_i;
`ifdef SRAM_ARB_IBUF_EN
                        ibuf_valid_d = 1'b1;
                        ibuf_addr_d  = addr_q;
                        ibuf_word_d  = sram_rdata_i;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                cnt_d   = 3'd0;
            end
            WR_PULSE: begin
                if (cnt_q == WE_LAST) state_d = WR_HOLD;
                else                  cnt_d   = cnt_q + 3'd1;
            end
            WR_HOLD: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode straight from the state register, so a reset clears them at the next edge.
    always_comb begin
        sram_ce_n_o  = 1'b1;
        sram_oe_n_o  = 1'b1;
        sram_we_n_o  = 1'b1;
        sram_be_n_o  = 4'hF;
        sram_dq_oe_o = 1'b0;
        case (state_q)
            RD: begin
                sram_ce_n_o = 1'b0;
                sram_oe_n_o = 1'b0;
                sram_be_n_o = ~be_q;
            end
            WR_SETUP, WR_HOLD: begin
                sram_ce_n_o  = 1'b0;
                sram_be_n_o  = ~be_q;
                sram_dq_oe_o = 1'b1;
            end
            WR_PULSE: begin
                sram_ce_n_o  = 1'b0;
                sram_we_n_o  = 1'b0;
                sram_be_n_o  = ~be_q;
                sram_dq_oe_o = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: state uses non-blocking assignments; reset is synchronous to clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_INST;
            addr_q       <= 20'h0;
            we_q         <= 1'b0;
            be_q         <= 4'h0;
            wdata_q      <= 32'h0;
            cnt_q        <= 3'd0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
`ifdef SRAM_ARB_IBUF_EN
            ibuf_valid_q <= 1'b0;
            ibuf_addr_q  <= 20'h0;
            ibuf_word_q  <= 32'h0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
`ifdef SRAM_ARB_IBUF_EN
            ibuf_valid_q <= ibuf_valid_d;
            ibuf_addr_q  <= ibuf_addr_d;
            ibuf_word_q  <= ibuf_word_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a byte-writable SRAM model (READ_WAIT=1, WE_PULSE=1).
// Expectations adapt to SRAM_ARB_IBUF_EN when that macro is defined.
module tb_sram_port_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req_i;
    logic [19:0] inst_addr_i;
    logic [31:0] inst_rdata_o;
    logic        inst_ack_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [19:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_ack_o;
    logic        stall_o;
    logic [19:0] sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i;
    logic        sram_dq_oe_o;
    logic        sram_ce_n_o;
    logic        sram_oe_n_o;
    logic        sram_we_n_o;
    logic [3:0]  sram_be_n_o;

    sram_port_arbiter #(.READ_WAIT(1), .WE_PULSE(1)) dut (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
        .inst_rdata_o(inst_rdata_o), .inst_ack_o(inst_ack_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rdata_o(data_rdata_o), .data_ack_o(data_ack_o),
        .stall_o(stall_o),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
        .sram_dq_oe_o(sram_dq_oe_o), .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o),
        .sram_we_n_o(sram_we_n_o), .sram_be_n_o(sram_be_n_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: preloaded on reset, byte writes while ce_n and we_n are both low.
    logic [31:0] mem [0:2047];
    always @(posedge clk) begin
        if (rst) begin
            mem[16]   <= 32'h2402_0005;
            mem[32]   <= 32'h0BAD_F00D;
            mem[1024] <= 32'h1122_3344;
        end else if (!sram_ce_n_o && !sram_we_n_o) begin
            for (int b = 0; b < 4; b++)
                if (!sram_be_n_o[b]) mem[sram_addr_o[10:0]][8*b +: 8] <= sram_wdata_o[8*b +: 8];
        end
    end
    assign sram_rdata_i = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[10:0]] : 32'h0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        port;     // 0 = fetch, 1 = data
        logic        we;
        logic [3:0]  be;
        logic [19:0] addr;
        logic [31:0] wdata;
        int          lat;      // grant cycle to ack cycle
        logic [31:0] rdata;
        int          ce_cyc;
        int          oe_cyc;
        int          we_cyc;
        int          dq_cyc;
        logic [3:0]  be_n_we;  // sram_be_n_o while we_n is low
    } vec_t;

    vec_t vecs[11];

    task automatic run_vec(input int idx);
        vec_t v;
        int lat, ce_c, oe_c, we_c, dq_c, other, stall_bad;
        logic [31:0] rdata;
        logic [3:0] bn;
        logic done;
        v = vecs[idx];
        lat = 0; ce_c = 0; oe_c = 0; we_c = 0; dq_c = 0; other = 0; stall_bad = 0;
        rdata = 32'h0; bn = 4'hF; done = 1'b0;
        if (v.port) begin
            data_req_i = 1'b1; data_we_i = v.we; data_be_i = v.be;
            data_addr_i = v.addr; data_wdata_i = v.wdata;
        end else begin
            inst_req_i = 1'b1; inst_addr_i = v.addr;
        end
        while (!done && lat < 50) begin
            @(negedge clk);
            if (!sram_ce_n_o) ce_c++;
            if (!sram_oe_n_o) oe_c++;
            if (sram_dq_oe_o) dq_c++;
            if (!sram_we_n_o) begin we_c++; bn = sram_be_n_o; end
            if (v.port ? inst_ack_o : data_ack_o) other++;
            if (v.port ? data_ack_o : inst_ack_o) begin
                done = 1'b1;
                rdata = v.port ? data_rdata_o : inst_rdata_o;
                if (stall_o) stall_bad++;
            end else begin
                if (!stall_o) stall_bad++;
                @(posedge clk); #1;
                lat++;
            end
        end
        check($sformatf("v%0d_ack_seen", idx), {31'h0, done}, 32'h1);
        @(posedge clk); #1;
        inst_req_i = 1'b0; data_req_i = 1'b0;
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d_ce_cycles", idx), 32'(ce_c), 32'(v.ce_cyc));
        check($sformatf("v%0d_oe_cycles", idx), 32'(oe_c), 32'(v.oe_cyc));
        check($sformatf("v%0d_we_cycles", idx), 32'(we_c), 32'(v.we_cyc));
        check($sformatf("v%0d_dq_oe_cycles", idx), 32'(dq_c), 32'(v.dq_cyc));
        check($sformatf("v%0d_other_ack", idx), 32'(other), 32'h0);
        check($sformatf("v%0d_stall", idx), 32'(stall_bad), 32'h0);
        if (!v.we) check($sformatf("v%0d_rdata", idx), rdata, v.rdata);
        if (v.we_cyc > 0) check($sformatf("v%0d_be_n", idx), {28'h0, bn}, {28'h0, v.be_n_we});
    endtask

    initial begin
        int order[$];
        int acks;
        logic seen;

        //          port  we    be    addr      wdata          lat rdata          ce oe we dq be_n
        vecs[0]  = '{1'b0, 1'b0, 4'hF, 20'h00010, 32'h0,         3, 32'h2402_0005, 2, 2, 0, 0, 4'hF};
        vecs[1]  = '{1'b1, 1'b1, 4'h3, 20'h00400, 32'hDEAD_BEEF, 4, 32'h0,         3, 0, 1, 3, 4'hC};
        vecs[2]  = '{1'b1, 1'b1, 4'h0, 20'h00400, 32'hCAFE_F00D, 1, 32'h0,         0, 0, 0, 0, 4'hF};
        vecs[3]  = '{1'b1, 1'b0, 4'hF, 20'h00400, 32'h0,         3, 32'h1122_BEEF, 2, 2, 0, 0, 4'hF};
        vecs[4]  = '{1'b1, 1'b1, 4'h8, 20'h00010, 32'hAA00_0000, 4, 32'h0,         3, 0, 1, 3, 4'h7};
        vecs[5]  = '{1'b1, 1'b0, 4'h5, 20'h00010, 32'h0,         3, 32'hAA02_0005, 2, 2, 0, 0, 4'hF};
        vecs[6]  = '{1'b0, 1'b0, 4'hF, 20'h00010, 32'h0,         3, 32'hAA02_0005, 2, 2, 0, 0, 4'hF};
        vecs[7]  = '{1'b0, 1'b0, 4'hF, 20'h00020, 32'h0,         3, 32'h0BAD_F00D, 2, 2, 0, 0, 4'hF};
`ifdef SRAM_ARB_IBUF_EN
        vecs[8]  = '{1'b0, 1'b0, 4'hF, 20'h00020, 32'h0,         1, 32'h0BAD_F00D, 0, 0, 0, 0, 4'hF};
`else
        vecs[8]  = '{1'b0, 1'b0, 4'hF, 20'h00020, 32'h0,         3, 32'h0BAD_F00D, 2, 2, 0, 0, 4'hF};
`endif
        vecs[9]  = '{1'b1, 1'b1, 4'hF, 20'h00020, 32'h1234_5678, 4, 32'h0,         3, 0, 1, 3, 4'h0};
        vecs[10] = '{1'b0, 1'b0, 4'hF, 20'h00020, 32'h0,         3, 32'h1234_5678, 2, 2, 0, 0, 4'hF};

        rst = 1'b1;
        inst_req_i = 1'b0; inst_addr_i = 20'h0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
        data_addr_i = 20'h0; data_wdata_i = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_strobes", {28'h0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_dq_oe_o}, 32'hE);
        check("rst_be_n", {28'h0, sram_be_n_o}, 32'hF);
        check("rst_addr", {12'h0, sram_addr_o}, 32'h0);
        check("rst_wdata", sram_wdata_o, 32'h0);
        check("rst_acks_stall", {29'h0, inst_ack_o, data_ack_o, stall_o}, 32'h0);
        check("rst_inst_rdata", inst_rdata_o, 32'h0);
        check("rst_data_rdata", data_rdata_o, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(i);

        // Both ports request back to back; the previous grant went to fetch, so data leads.
        inst_addr_i = 20'h00020;
        data_addr_i = 20'h00400; data_we_i = 1'b0; data_be_i = 4'hF;
        inst_req_i = 1'b1; data_req_i = 1'b1;
        for (int c = 0; c < 80 && order.size() < 4; c++) begin
            @(negedge clk);
            if (inst_ack_o && data_ack_o) order.push_back(2);
            else if (data_ack_o)          order.push_back(1);
            else if (inst_ack_o)          order.push_back(0);
            @(posedge clk); #1;
        end
        inst_req_i = 1'b0; data_req_i = 1'b0;
        check("rr_ack_count", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_grant%0d", i), (i < order.size()) ? 32'(order[i]) : 32'd99,
                  (i % 2 == 0) ? 32'd1 : 32'd0);

        // Reset while the write pulse is active.
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF;
        data_addr_i = 20'h00300; data_wdata_i = 32'h0000_0055;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (!sram_we_n_o) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("wr_pulse_reached", {31'h0, seen}, 32'h1);
        rst = 1'b1; data_req_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_strobes", {28'h0, sram_ce_n_o, sram_we_n_o, sram_dq_oe_o, sram_oe_n_o}, 32'hD);
        check("abort_be_n", {28'h0, sram_be_n_o}, 32'hF);
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            if (inst_ack_o || data_ack_o) acks++;
            @(negedge clk);
        end
        check("abort_no_ack", 32'(acks), 32'h0);
        check("abort_data_rdata", data_rdata_o, 32'h0);
        @(posedge clk); #1;

        for (int i = 7; i < 11; i++) run_vec(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got expired, want finished");
        $fatal(1);
    end

endmodule
